// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter and its read-tag FIFO.
package sdram_arb_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

    localparam int NUM_PORTS_DEFAULT  = 4;
    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int PORT_IDX_W         = clog2(NUM_PORTS_DEFAULT);
    localparam int BE_WIDTH           = DATA_WIDTH_DEFAULT / 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of issuing port indices for reads still awaiting data.
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin N-port Avalon-MM front end for the single-master SDRAM controller port.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_READS  = 8
) (
    input  logic                              clk_in_clk,
    input  logic                              reset_reset,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   client_address,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] client_byteenable_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   client_writedata,
    input  logic [NUM_PORTS-1:0]              client_read_n,
    input  logic [NUM_PORTS-1:0]              client_write_n,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   client_readdata,
    output logic [NUM_PORTS-1:0]              client_readdatavalid,
    output logic [NUM_PORTS-1:0]              client_waitrequest,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [DATA_WIDTH/8-1:0]           mem_byteenable_n,
    output logic                              mem_chipselect,
    output logic [DATA_WIDTH-1:0]             mem_writedata,
    output logic                              mem_read_n,
    output logic                              mem_write_n,
    input  logic [DATA_WIDTH-1:0]             mem_readdata,
    input  logic                              mem_readdatavalid,
    input  logic                              mem_waitrequest,
    output logic                              err_orphan
);

    localparam int IDX_W = clog2(NUM_PORTS);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = clog2(MAX_READS) + 1;

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    locked_port;
    logic [IDX_W-1:0]    grant_idle;
    logic [IDX_W-1:0]    grant;
    logic [IDX_W-1:0]    sel;
    logic                found;
    logic                active;
    logic                is_write;
    logic                accept;
    logic                push;
    logic                route;
    logic [NUM_PORTS-1:0] wr_req;
    logic [NUM_PORTS-1:0] rd_req;
    logic [NUM_PORTS-1:0] elig;
    logic [IDX_W-1:0]    tag_out;
    logic [CNT_W-1:0]    tag_count;
    logic                tag_full;
    logic                tag_empty;

    // A simultaneous read and write on one port is treated as a write.
    assign wr_req = ~client_write_n;
    assign rd_req = ~client_read_n & client_write_n;
    assign elig   = wr_req | (rd_req & {NUM_PORTS{tag_count < CNT_W'(MAX_READS)}});

    always_comb begin
        int idx;
        found      = 1'b0;
        grant_idle = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant_idle = IDX_W'(idx);
            end
        end
    end

    // NOTE: reset also gates the combinational request path so nothing reaches the controller while reset is held.
    assign grant    = (state == LOCKED) ? locked_port : grant_idle;
    assign active   = ~reset_reset & ((state == LOCKED) ? elig[locked_port] : found);
    assign is_write = wr_req[grant];
    assign accept   = active & ~mem_waitrequest;
    assign push     = accept & ~is_write & ~tag_full;
    assign sel      = active ? grant : '0;

    assign mem_address      = client_address[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_writedata    = client_writedata[sel*DATA_WIDTH +: DATA_WIDTH];
    assign mem_byteenable_n = client_byteenable_n[sel*BE_W +: BE_W];
    assign mem_chipselect   = active;
    assign mem_write_n      = ~(active & is_write);
    assign mem_read_n       = ~(active & ~is_write);

    assign route           = ~reset_reset & mem_readdatavalid & ~tag_empty;
    assign client_readdata = {NUM_PORTS{mem_readdata}};

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            client_waitrequest[k]   = ~(accept && grant == IDX_W'(k));
            client_readdatavalid[k] = route && tag_out == IDX_W'(k);
        end
    end

    always_ff @(posedge clk_in_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state       <= IDLE;
            locked_port <= '0;
            rr_ptr      <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (accept)
                rr_ptr <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + IDX_W'(1);
            if (mem_readdatavalid && tag_empty)
                err_orphan <= 1'b1;
            case (state)
                IDLE: begin
                    if (active && mem_waitrequest) begin
                        state       <= LOCKED;
                        locked_port <= grant;
                    end
                end
                LOCKED: begin
                    if (!active || !mem_waitrequest) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sdram_tag_fifo #(
        .DEPTH (MAX_READS),
        .WIDTH (IDX_W)
    ) u_tag_fifo (
        .clk       (clk_in_clk),
        .rst       (reset_reset),
        .push      (push),
        .push_data (grant),
        .pop       (mem_readdatavalid),
        .pop_data  (tag_out),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: grant/hold behaviour and scoreboarded read-return routing.
module tb_sdram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int MR = 8;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] client_address;
    logic [N*BW-1:0] client_byteenable_n;
    logic [N*DW-1:0] client_writedata;
    logic [N-1:0]    client_read_n;
    logic [N-1:0]    client_write_n;
    logic [N*DW-1:0] client_readdata;
    logic [N-1:0]    client_readdatavalid;
    logic [N-1:0]    client_waitrequest;
    logic [AW-1:0]   mem_address;
    logic [BW-1:0]   mem_byteenable_n;
    logic            mem_chipselect;
    logic [DW-1:0]   mem_writedata;
    logic            mem_read_n;
    logic            mem_write_n;
    logic [DW-1:0]   mem_readdata;
    logic            mem_readdatavalid;
    logic            mem_waitrequest;
    logic            err_orphan;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_tag[$];
    int exp_grant[$];

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_PORTS  (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_READS  (MR)
    ) dut (
        .clk_in_clk           (clk),
        .reset_reset          (rst),
        .client_address       (client_address),
        .client_byteenable_n  (client_byteenable_n),
        .client_writedata     (client_writedata),
        .client_read_n        (client_read_n),
        .client_write_n       (client_write_n),
        .client_readdata      (client_readdata),
        .client_readdatavalid (client_readdatavalid),
        .client_waitrequest   (client_waitrequest),
        .mem_address          (mem_address),
        .mem_byteenable_n     (mem_byteenable_n),
        .mem_chipselect       (mem_chipselect),
        .mem_writedata        (mem_writedata),
        .mem_read_n           (mem_read_n),
        .mem_write_n          (mem_write_n),
        .mem_readdata         (mem_readdata),
        .mem_readdatavalid    (mem_readdatavalid),
        .mem_waitrequest      (mem_waitrequest),
        .err_orphan           (err_orphan)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic idle_all();
        client_read_n     = '1;
        client_write_n    = '1;
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b0;
        mem_readdata      = '0;
    endtask

    task automatic req_write(input int k);
        client_write_n[k] = 1'b0;
    endtask

    task automatic req_read(input int k);
        client_read_n[k] = 1'b0;
    endtask

    function automatic int granted();
        int g;
        g = -1;
        for (int k = 0; k < N; k++)
            if (!client_waitrequest[k]) g = (g == -1) ? k : -2;
        return g;
    endfunction

    // Compare one read-return cycle against the oldest outstanding tag in the scoreboard.
    task automatic rd_return(input logic [DW-1:0] data);
        logic [N-1:0] exp_strobe;
        exp_strobe = '0;
        if (exp_tag.size() > 0) exp_strobe[exp_tag.pop_front()] = 1'b1;
        check("rdv_strobe", 64'(client_readdatavalid), 64'(exp_strobe));
        if (exp_strobe != '0)
            check("rdv_data", 64'(client_readdata), 64'({N{data}}));
    endtask

    task automatic expect_read_accept(input int k);
        check("rd_grant", 64'(granted()), 64'(k));
        check("rd_mem_read_n", 64'(mem_read_n), 64'(0));
        check("rd_addr", 64'(mem_address), 64'(32'h1000 + k));
        exp_tag.push_back(k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            client_address[k*AW +: AW]      = AW'(32'h1000 + k);
            client_writedata[k*DW +: DW]    = DW'(32'hD000 + k);
            client_byteenable_n[k*BW +: BW] = BW'(k);
        end
        idle_all();
        req_write(0);
        mem_readdatavalid = 1'b1;

        // Reset state with a request and a stray return present
        @(negedge clk); #1;
        check("rst_cs", 64'(mem_chipselect), 64'(0));
        check("rst_read_n", 64'(mem_read_n), 64'(1));
        check("rst_write_n", 64'(mem_write_n), 64'(1));
        check("rst_waitreq", 64'(client_waitrequest), 64'(4'hF));
        check("rst_rdv", 64'(client_readdatavalid), 64'(0));
        check("rst_orphan", 64'(err_orphan), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        idle_all();

        // Port 2 write held off by the controller for three cycles
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_all();
            req_write(2);
            mem_waitrequest = (c < 3);
            #1;
            check("hold_cs", 64'(mem_chipselect), 64'(1));
            check("hold_write_n", 64'(mem_write_n), 64'(0));
            check("hold_addr", 64'(mem_address), 64'(32'h1002));
            check("hold_wdata", 64'(mem_writedata), 64'(16'hD002));
            check("hold_be", 64'(mem_byteenable_n), 64'(2));
            check("hold_waitreq", 64'(client_waitrequest), (c < 3) ? 64'(4'hF) : 64'(4'hB));
        end

        // All ports writing: rotation starts after port 2
        exp_grant = '{3, 0, 1, 2, 3, 0};
        while (exp_grant.size() > 0) begin
            int g;
            g = exp_grant.pop_front();
            @(negedge clk);
            idle_all();
            for (int k = 0; k < N; k++) req_write(k);
            #1;
            check("rot_grant", 64'(granted()), 64'(g));
            check("rot_addr", 64'(mem_address), 64'(32'h1000 + g));
        end

        // Port 1 reads until the tag FIFO is full
        for (int c = 0; c < MR; c++) begin
            @(negedge clk);
            idle_all();
            req_read(1);
            #1;
            expect_read_accept(1);
        end
        @(negedge clk);
        idle_all();
        req_read(1);
        #1;
        check("full_waitreq", 64'(client_waitrequest), 64'(4'hF));
        check("full_cs", 64'(mem_chipselect), 64'(0));
        check("full_count", 64'(dut.tag_count), 64'(MR));
        @(negedge clk);
        idle_all();
        req_read(1);
        mem_readdatavalid = 1'b1;
        mem_readdata      = 16'h5A5A;
        #1;
        check("free_waitreq", 64'(client_waitrequest), 64'(4'hF));
        rd_return(16'h5A5A);
        @(negedge clk);
        idle_all();
        req_read(1);
        #1;
        check("ninth_count", 64'(dut.tag_count), 64'(MR - 1));
        expect_read_accept(1);
        for (int i = 0; i < MR; i++) begin
            @(negedge clk);
            idle_all();
            mem_readdatavalid = 1'b1;
            mem_readdata      = DW'(32'h0100 + i);
            #1;
            rd_return(DW'(32'h0100 + i));
        end

        // Reads from ports 3, 0, 3, then one cycle with push and pop together
        for (int i = 0; i < 3; i++) begin
            int p;
            p = (i == 1) ? 0 : 3;
            @(negedge clk);
            idle_all();
            req_read(p);
            #1;
            expect_read_accept(p);
        end
        @(negedge clk);
        idle_all();
        req_read(0);
        mem_readdatavalid = 1'b1;
        mem_readdata      = 16'h00A1;
        #1;
        rd_return(16'h00A1);
        expect_read_accept(0);
        @(negedge clk);
        idle_all();
        mem_readdatavalid = 1'b1;
        mem_readdata      = 16'h00B2;
        #1;
        check("pushpop_count", 64'(dut.tag_count), 64'(3));
        rd_return(16'h00B2);
        @(negedge clk);
        idle_all();
        mem_readdatavalid = 1'b1;
        mem_readdata      = 16'h00C3;
        #1;
        rd_return(16'h00C3);
        @(negedge clk);
        idle_all();
        mem_readdatavalid = 1'b1;
        mem_readdata      = 16'h00D4;
        #1;
        rd_return(16'h00D4);
        @(negedge clk);
        idle_all();
        #1;
        check("drain_count", 64'(dut.tag_count), 64'(0));

        // Orphan return with an empty FIFO
        @(negedge clk);
        idle_all();
        mem_readdatavalid = 1'b1;
        mem_readdata      = 16'h00EE;
        #1;
        rd_return(16'h00EE);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle_all();
            #1;
            check("orphan_sticky", 64'(err_orphan), 64'(1));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("orphan_cleared", 64'(err_orphan), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Reset while LOCKED with three reads outstanding
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_all();
            req_read(2);
            #1;
            expect_read_accept(2);
        end
        @(negedge clk);
        idle_all();
        req_write(2);
        mem_waitrequest = 1'b1;
        #1;
        check("lock_cs", 64'(mem_chipselect), 64'(1));
        check("lock_waitreq", 64'(client_waitrequest), 64'(4'hF));
        @(negedge clk);
        idle_all();
        req_write(2);
        req_write(1);
        mem_waitrequest = 1'b1;
        #1;
        check("locked_addr", 64'(mem_address), 64'(32'h1002));
        @(negedge clk);
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b1;
        rst               = 1'b1;
        #1;
        exp_tag.delete();
        check("rstlock_cs", 64'(mem_chipselect), 64'(0));
        check("rstlock_waitreq", 64'(client_waitrequest), 64'(4'hF));
        check("rstlock_rdv", 64'(client_readdatavalid), 64'(0));
        check("rstlock_write_n", 64'(mem_write_n), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        idle_all();
        for (int k = 0; k < N; k++) req_write(k);
        #1;
        check("post_rst_count", 64'(dut.tag_count), 64'(0));
        check("post_rst_grant", 64'(granted()), 64'(0));
        @(negedge clk);
        idle_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- N-port Avalon-MM front end for the single-master SDRAM controller interface.
- Arbitrates client read and write requests round-robin.
- Holds the grant stable while the controller stalls.
- Routes pipelined read data back to the issuing port through an in-order tag FIFO.
- Sits between application masters (camera, CPU, display) and the SDRAM controller's interface_* slave port.

Parameters:
NUM_PORTS, 4, number of client ports (2..8)
ADDR_WIDTH, 22, word address width
DATA_WIDTH, 16, data width; must be a multiple of 8
MAX_READS, 8, maximum outstanding reads; power of two, at least 2

Ports:
clk_in_clk  in  1  single clock domain
reset_reset  in  1  asynchronous, active-high reset
client_address  in  NUM_PORTS*ADDR_WIDTH  packed per-port address, port k at slice k
client_byteenable_n  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, active low
client_writedata  in  NUM_PORTS*DATA_WIDTH  per-port write data
client_read_n  in  NUM_PORTS  per-port read request, active low
client_write_n  in  NUM_PORTS  per-port write request, active low
client_readdata  out  NUM_PORTS*DATA_WIDTH  per-port read data
client_readdatavalid  out  NUM_PORTS  per-port read data strobe
client_waitrequest  out  NUM_PORTS  per-port stall
mem_address  out  ADDR_WIDTH  to controller interface_address
mem_byteenable_n  out  DATA_WIDTH/8  to controller
mem_chipselect  out  1  to controller
mem_writedata  out  DATA_WIDTH  to controller
mem_read_n  out  1  to controller
mem_write_n  out  1  to controller
mem_readdata  in  DATA_WIDTH  from controller
mem_readdatavalid  in  1  from controller
mem_waitrequest  in  1  from controller
err_orphan  out  1  sticky: readdatavalid received with no outstanding tag

Behaviour:
- Request on port k: req[k] = ~client_read_n[k] | ~client_write_n[k].
  - If both are low, the write wins; the read is ignored for that transfer.
- Eligibility:
  - A write request is always eligible.
  - A read request is eligible only if the tag count is below MAX_READS. Count is the registered value, before this cycle's push/pop.
- State machine with two states:
  - IDLE:
    - Grant goes to the first eligible port at or after rr_ptr, searching ascending with wrap.
    - The granted request is driven to mem_* combinationally in the same cycle.
    - If mem_waitrequest is 1, latch the grant and go to LOCKED.
  - LOCKED:
    - The grant is fixed, and mem_* follows that port's inputs.
    - Stay in LOCKED until mem_waitrequest is 0, then return to IDLE.
    - The client must hold its request (Avalon rule). If the client withdraws its request, drop the mem request and return to IDLE.
- Accept: mem request active and mem_waitrequest = 0.
  - rr_ptr <= (granted + 1) mod NUM_PORTS.
  - A read accept pushes the port index into the tag FIFO.
- client_waitrequest[k]:
  - 0 only when port k is granted and mem_waitrequest = 0.
  - Otherwise 1, including when the port is idle.
- mem_chipselect = 1 exactly when a request is driven. The mem_read_n / mem_write_n pair is active for the selected operation only.
- Read return, on mem_readdatavalid:
  - Pop the tag FIFO.
  - client_readdatavalid[tag] = 1 in the same cycle, zero added latency.
  - client_readdata for all ports = mem_readdata, broadcast; only the strobe is per port.
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged.
  - Pop when empty: nothing routed, err_orphan set to 1 (sticky until reset).
  - Push is never attempted when full, because eligibility blocks it.
- No request pending: mem_chipselect = 0, mem_read_n = mem_write_n = 1; address, data and byte enables are driven from port 0 as don't-care.
- Reset, asynchronous, any state:
  - State returns to IDLE, rr_ptr = 0.
  - FIFO cleared, err_orphan = 0.
  - Outputs held at: mem_chipselect = 0, mem_read_n = mem_write_n = 1, client_waitrequest all 1, client_readdatavalid all 0.
  - Outstanding reads are discarded. The SDRAM controller shares this reset, so no stale data returns.

Decomposition:
- Package sdram_arb_pkg: PORT_IDX_W = clog2(NUM_PORTS), BE_WIDTH = DATA_WIDTH/8, state enum {IDLE, LOCKED}, and the clog2 function.
- One sub-module, sdram_tag_fifo: synchronous FIFO MAX_READS x PORT_IDX_W with count, full, empty, and async-reset pointers.

Test Plan:
- Single port 2 issues a write with mem_waitrequest held 1 for 3 cycles:
  - mem_* stay stable on port 2 data for 4 cycles.
  - client_waitrequest[2] = 0 only in cycle 4.
  - rr_ptr = 3 afterwards.
- All 4 ports request writes continuously, with mem_waitrequest = 0:
  - Grants rotate 0,1,2,3,0 with no port granted twice in a row.
- 9 back-to-back reads from port 1 with MAX_READS = 8 and no readdatavalid:
  - 8 are accepted, the 9th stalls.
  - One readdatavalid then frees a slot; the 9th is accepted in the next cycle.
- Reads accepted from ports 3, 0, 3, then mem_readdatavalid pulsed with data 0xA1, 0xB2, 0xC3:
  - client_readdatavalid strobes go to ports 3, 0, 3 in order, each with matching data.
- mem_readdatavalid with an empty FIFO:
  - err_orphan = 1 and stays 1.
  - No client strobe is produced.
  - reset_reset clears err_orphan.
- reset_reset asserted while LOCKED with 3 reads outstanding:
  - Immediately mem_chipselect = 0 and all client_waitrequest = 1.
  - After release the FIFO count is 0 and the first grant goes to port 0.
